sfu_norm_arbiter: RTL and testbench

- Shares one leading-one-detect/normalize datapath between N_REQ SFU function pipelines (reciprocal, sqrt, log, ...).
- Each requester produces a 27-bit unsigned fixed-point fraction (weights 2^-1..2^-27) plus a sign.
- The block arbitrates round-robin, registers the winner, normalizes it to an FP32 word, and returns it with the requester ID.
- It has a two-stage valid/ready pipeline with full backpressure and sits between the SFU kernels and the SFU result writeback.

---
 rtl/sfu_norm_pkg.sv | 16 +
 rtl/sfu_norm_lod.sv | 32 +++
 rtl/sfu_norm_arbiter.sv | 85 ++++++++
 tb/tb_sfu_norm_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sfu_norm_pkg.sv
// sfu_norm_pkg: shared widths and types for the SFU normalize arbiter
package sfu_norm_pkg;
  localparam int FRAC_W  = 27;
  localparam int MAN_W   = 23;
  localparam int EXP_W   = 8;
  localparam int EXP_TOP = 126;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
  typedef struct packed {
    logic [FRAC_W-1:0] frac;
    logic              sign;
  } norm_req_t;
endpackage

// File: rtl/sfu_norm_lod.sv
// sfu_norm_lod: leading-one detect and normalize of a 2^-1..2^-27 fraction to FP32 exp/man
// SFU_NORM_ROUND_EN selects round-to-nearest-even instead of truncation.
module sfu_norm_lod
  import sfu_norm_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  output logic [MAN_W-1:0]  man_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              zero_o
);
  logic [4:0]        pos;
  logic [FRAC_W-1:0] sh;
  logic [EXP_W-1:0]  exp_t;
  always_comb begin
    pos = '0;
    for (int i = 0; i < FRAC_W; i++) pos = frac_i[i] ? 5'(i) : pos;
    sh = frac_i << (5'(FRAC_W) - pos);
  end
  assign zero_o = ~|frac_i;
  assign exp_t  = 8'(EXP_TOP - (FRAC_W - 1)) + {3'b0, pos};
`ifdef SFU_NORM_ROUND_EN
  logic [MAN_W:0] man_r;
  logic           inc;
  assign inc   = sh[FRAC_W-MAN_W-1] & ((|sh[FRAC_W-MAN_W-2:0]) | sh[FRAC_W-MAN_W]);
  assign man_r = {1'b0, sh[FRAC_W-1 -: MAN_W]} + {{MAN_W{1'b0}}, inc};
  assign man_o = zero_o ? '0 : man_r[MAN_W-1:0];
  assign exp_o = zero_o ? '0 : exp_t + {{(EXP_W-1){1'b0}}, man_r[MAN_W]};
`else
  assign man_o = zero_o ? '0 : sh[FRAC_W-1 -: MAN_W];
  assign exp_o = zero_o ? '0 : exp_t;
`endif
endmodule

// File: rtl/sfu_norm_arbiter.sv
// sfu_norm_arbiter: round-robin share of one normalize datapath among N_REQ SFU pipelines
// Two-stage valid/ready pipeline; SFU_NORM_ROUND_EN enables RNE rounding in sfu_norm_lod.
module sfu_norm_arbiter
  import sfu_norm_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*FRAC_W-1:0] req_frac,
  input  logic [N_REQ-1:0]        req_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_zero,
  output logic                    busy
);
  logic            s1_valid_q, s2_valid_q, s1_adv, s2_adv, found, xfer;
  logic            out_zero_q, lod_zero;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant, s1_id_q, out_id_q;
  logic [MAN_W-1:0] lod_man;
  logic [EXP_W-1:0] lod_exp;
  norm_req_t       s1_q;
  fp32_t           out_data_q, norm;
  int              idx;
  assign s2_adv = !s2_valid_q | out_ready;
  assign s1_adv = !s1_valid_q | s2_adv;
  // Walk offsets high to low so the nearest valid index at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx   = int'(rr_ptr_q) + i;
      idx   = idx >= N_REQ ? idx - N_REQ : idx;
      found = req_valid[idx] ? 1'b1 : found;
      grant = req_valid[idx] ? ID_W'(idx) : grant;
    end
  end
  assign xfer      = found & s1_adv;
  assign rr_ptr_d  = int'(grant) == N_REQ - 1 ? '0 : grant + ID_W'(1);
  // Ready is masked by reset so it drops the moment rst_n falls.
  assign req_ready = (xfer & rst_n) ? N_REQ'(1) << grant : '0;
  sfu_norm_lod u_lod (
    .frac_i (s1_q.frac),
    .man_o  (lod_man),
    .exp_o  (lod_exp),
    .zero_o (lod_zero)
  );
  assign norm      = {s1_q.sign, lod_exp, lod_man};
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_zero  = out_zero_q;
  assign busy      = s1_valid_q | s2_valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rr_ptr_q   <= '0;
      s1_q       <= '0;
      s1_id_q    <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_zero_q <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= xfer;
      if (xfer) begin
        s1_q     <= {req_frac[int'(grant)*FRAC_W +: FRAC_W], req_sign[grant]};
        s1_id_q  <= grant;
        rr_ptr_q <= rr_ptr_d;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_adv & s1_valid_q) begin
        out_data_q <= norm;
        out_id_q   <= s1_id_q;
        out_zero_q <= lod_zero;
      end
    end
  end
endmodule

// File: tb/tb_sfu_norm_arbiter.sv
// tb_sfu_norm_arbiter: directed vector table plus round-robin, backpressure and reset sequences
module tb_sfu_norm_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0, req_ready, req_sign = '0;
  logic [N*27-1:0] req_frac = '0;
  logic          out_valid, out_ready = 1'b1, out_zero, busy;
  logic [31:0]   out_data, held;
  logic [1:0]    out_id;
  int tests = 0, fails = 0, ng = 0, ne = 0, acc = 0, con = 0;
  typedef struct {
    int          id;
    logic [26:0] frac;
    logic        sign;
    logic [31:0] data;
    logic        zero;
  } vec_t;
  vec_t vt [9];

  always #5 clk = ~clk;

  sfu_norm_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_frac(req_frac), .req_sign(req_sign), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_zero(out_zero), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rr_data(input int i);
    return {i[0], 8'(126 - i), 23'h0};
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_frac[27*v.id +: 27] = v.frac;
    req_sign[v.id] = v.sign;
    #1;
    chk("vec_ready", 32'(req_ready), 32'(4'b1 << v.id));
    @(negedge clk);
    req_valid = '0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("vec_latency", 32'(n), 32'd2);
    chk("vec_data", out_data, v.data);
    chk("vec_id", 32'(out_id), 32'(v.id));
    chk("vec_zero", 32'(out_zero), 32'(v.zero));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 27'h4000000, 1'b0, 32'h3F000000, 1'b0};
    vt[1] = '{1, 27'h6000000, 1'b0, 32'h3F400000, 1'b0};
    vt[2] = '{2, 27'h0000001, 1'b0, 32'h32000000, 1'b0};
    vt[3] = '{3, 27'h0000000, 1'b1, 32'h80000000, 1'b1};
    vt[5] = '{1, 27'h0000007, 1'b1, 32'hB3600000, 1'b0};
    vt[8] = '{0, 27'h0000000, 1'b0, 32'h00000000, 1'b1};
`ifdef SFU_NORM_ROUND_EN
    vt[4] = '{0, 27'h7FFFFFF, 1'b0, 32'h3F800000, 1'b0};
    vt[6] = '{2, 27'h400000C, 1'b0, 32'h3F000002, 1'b0};
    vt[7] = '{3, 27'h4000006, 1'b1, 32'hBF000001, 1'b0};
`else
    vt[4] = '{0, 27'h7FFFFFF, 1'b0, 32'h3F7FFFFF, 1'b0};
    vt[6] = '{2, 27'h400000C, 1'b0, 32'h3F000001, 1'b0};
    vt[7] = '{3, 27'h4000006, 1'b1, 32'hBF000000, 1'b0};
`endif
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i]) run_vec(vt[i]);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_frac[27*i +: 27] = 27'h4000000 >> i;
      req_sign[i] = i[0];
    end
    out_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 22; c++) begin
      out_ready = !(c >= 10 && c < 15);
      #1;
      if (!out_ready) begin
        chk("stall_ready", 32'(req_ready), 32'd0);
        if (c == 10) held = out_data;
        else chk("stall_hold", out_data, held);
      end else begin
        chk("rr_grant", 32'(req_ready), 32'(4'b1 << ng));
        ng = (ng + 1) % N;
        acc++;
      end
      chk(c < 2 ? "fill_valid" : "tput_valid", 32'(out_valid), c < 2 ? 32'd0 : 32'd1);
      if (out_valid && out_ready) begin
        chk("rr_id", 32'(out_id), 32'(ne));
        chk("rr_data", out_data, rr_data(ne));
        ne = (ne + 1) % N;
        con++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        chk("drain_id", 32'(out_id), 32'(ne));
        chk("drain_data", out_data, rr_data(ne));
        ne = (ne + 1) % N;
        con++;
      end
      @(negedge clk);
    end
    chk("no_loss", 32'(con), 32'(acc));
    chk("idle_busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
